vga_sync_decoder: RTL
=====================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator. Consumes Hsync/Vsync on the 25 MHz pixel clock and recovers the line and frame position, the pixel coordinates and the active-video window.
- Checks every line and frame against the configured 640x480@60 timing and reports lock and error status.
- Used in the design as a self-check monitor on vga_controller outputs, and as the coordinate source for bench scoreboards of graphics_gen.

Parameters:
H_SYNC, 96, hsync low width in clocks
H_BACK, 48, back porch clocks after hsync
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, clocks per line
V_SYNC, 2, vsync low width in lines
V_BACK, 33, back porch lines
V_ACTIVE, 480, visible lines per frame
V_TOTAL, 525, lines per frame
LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
clk  in  1  pixel clock (same 25 MHz clock as the VGA generator)
rst  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active low
vsync  in  1  vertical sync, active low
pixel_x  out  10  active-region column 0..639; 0 when active=0
pixel_y  out  10  active-region row 0..479; 0 when active=0
active  out  1  high inside the visible window while locked
frame_start  out  1  one-clock pulse at each detected frame start
locked  out  1  timing lock status
err_pulse  out  1  one-clock pulse per detected timing violation
err_count  out  8  saturating violation count

Behaviour:
- Reset (rst=0, async): all counters 0, FSM=SEARCH, hsync_q=vsync_q=1. All outputs 0.
- Edge detect uses hsync_q/vsync_q, the previous-cycle samples.
  - hs_fall = hsync_q & ~hsync; hs_rise = ~hsync_q & hsync.
- h_cnt (10b):
  - On hs_fall, h_cnt <= 0.
  - Otherwise h_cnt <= h_cnt+1, saturating at 1023.
  - So h_cnt=0 in the cycle after hsync is first sampled low.
- v_cnt (10b) updates only on hs_fall:
  - If vsync=0 and the vsync value latched at the previous hs_fall was 1, this is a frame start and v_cnt <= 0.
  - Otherwise v_cnt <= v_cnt+1, saturating at 1023.
  - Vsync falling in the same clock as hsync counts as that line's frame start.
- frame_start: high for exactly the one clock after a frame-start hs_fall, in every FSM state.
- Window (combinational from registered counters):
  - hwin = H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE.
  - vwin = V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
  - active = locked & hwin & vwin.
  - pixel_x = h_cnt-(H_SYNC+H_BACK) and pixel_y = v_cnt-(V_SYNC+V_BACK) when active; otherwise 0.
- Checks, armed only in TRACK and LOCKED; each failure is one violation:
  - C1: hs_fall with h_cnt != H_TOTAL-1 (line length).
  - C2: hs_rise with h_cnt != H_SYNC-1 (hsync width).
  - C3: frame-start hs_fall with v_cnt != V_TOTAL-1 (frame length).
  - C4: h_cnt reaches H_TOTAL with no hs_fall (hsync lost); flagged once, in the cycle h_cnt becomes H_TOTAL.
  - Several checks failing in one clock count as one violation.
- FSM:
  - SEARCH -> TRACK on the first frame start; good_frames <= 0.
  - TRACK: on each frame start with no violation since the previous one, good_frames++. When good_frames reaches LOCK_FRAMES -> LOCKED.
  - TRACK or LOCKED -> SEARCH on any violation; good_frames cleared.
  - locked = (state==LOCKED), registered.
- On violation:
  - err_pulse=1 for one clock.
  - err_count increments, saturating at 255; cleared only by reset.
- Reset asserted mid-frame: immediate return to the reset state; a fresh lock needs 1 frame start plus LOCK_FRAMES clean frames.

Test Plan:
1. Reset, then 4 nominal frames (800x525 clocks, hsync low 96, vsync low 2 lines) -> frame_start pulses each frame; locked rises at the 3rd frame start; err_count=0.
2. Locked; probe the 1st visible pixel -> active=1 with pixel_x=0, pixel_y=0 at h_cnt=144, v_cnt=35; last pixel is pixel_x=639, pixel_y=479 at h_cnt=783, v_cnt=514; active=0 at h_cnt=784.
3. Locked; one line shortened to 799 clocks -> single err_pulse, err_count=1, locked=0; relock after 3 further frame starts.
4. Locked; hsync low for 95 clocks on one line -> err_pulse on the rise, err_count increments by 1, FSM=SEARCH.
5. Locked; hsync held high -> exactly one err_pulse when h_cnt hits 800; h_cnt saturates at 1023; active=0.
6. Force 300 violations -> err_count holds at 255. Assert rst mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers line/frame position and pixel coordinates from VGA hsync/vsync,
// validates every line and frame against the nominal timing and tracks lock.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       active,
    output logic       frame_start,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_LAST = 10'(H_SYNC - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [7:0] good_frames, good_nxt;
    logic       hsync_q;
    logic       vs_line;
    logic [9:0] h_cnt, v_cnt;

    logic hs_fall, hs_rise, fs_det, viol;
    logic hwin, vwin;

    assign hs_fall = hsync_q & ~hsync;
    assign hs_rise = ~hsync_q & hsync;
    // vs_line holds vsync as seen at the previous line start, so a frame
    // begins on the first line start that finds vsync low.
    assign fs_det  = hs_fall & ~vsync & vs_line;

    always_comb begin
        viol = 1'b0;
        if (state != SEARCH) begin
            viol = (hs_fall && h_cnt != H_LAST)  ||
                   (hs_rise && h_cnt != HS_LAST) ||
                   (fs_det  && v_cnt != V_LAST)  ||
                   (!hs_fall && h_cnt == H_LAST);
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        case (state)
            SEARCH: begin
                if (fs_det) begin
                    state_nxt = TRACK;
                    good_nxt  = 8'd0;
                end
            end
            TRACK: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    good_nxt  = 8'd0;
                end else if (fs_det) begin
                    good_nxt = good_frames + 8'd1;
                    if (good_nxt >= LOCK_N) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_nxt = SEARCH;
                    good_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            good_frames <= 8'd0;
            hsync_q     <= 1'b1;
            vs_line     <= 1'b1;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            frame_start <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_nxt;
            good_frames <= good_nxt;
            hsync_q     <= hsync;
            frame_start <= fs_det;
            err_pulse   <= viol;
            if (viol && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (hs_fall)                h_cnt <= 10'd0;
            else if (h_cnt != 10'h3FF)  h_cnt <= h_cnt + 10'd1;

            if (hs_fall) begin
                vs_line <= vsync;
                if (fs_det)                 v_cnt <= 10'd0;
                else if (v_cnt != 10'h3FF)  v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    assign locked  = (state == LOCKED);
    assign hwin    = (h_cnt >= H_START) && (h_cnt < H_END);
    assign vwin    = (v_cnt >= V_START) && (v_cnt < V_END);
    assign active  = locked & hwin & vwin;
    assign pixel_x = active ? (h_cnt - H_START) : 10'd0;
    assign pixel_y = active ? (v_cnt - V_START) : 10'd0;

endmodule
